// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the sequential divide/modulo unit.
// Flag layout matches the other ALU units.
package cpu_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam logic OP_MOD = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  // N and C are always clear for this unsigned unit.
  function automatic logic [3:0] make_flags(input logic zero, input logic ovf);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = zero;
    f[FLG_V] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/div_mod_seq_if.sv
// Request/response bundle between the execute stage (master) and the divide unit (slave).
interface div_mod_seq_if #(
  parameter int unsigned n = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] c;
  logic [3:0]   banderas;
  logic         busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c, banderas, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c, banderas, busy
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and record the quotient bit.
module div_step #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] rem,
  input  logic [n-1:0] quo,
  input  logic [n-1:0] b,
  output logic [n-1:0] rem_nxt,
  output logic [n-1:0] quo_nxt
);

  logic [n:0]   t;
  logic [n-1:0] diff;
  logic         ge;

  // When ge holds the true difference is below b, so its low n bits are exact.
  always_comb begin
    t       = {rem, quo[n-1]};
    ge      = (t >= {1'b0, b});
    diff    = t[n-1:0] - b;
    rem_nxt = ge ? diff : t[n-1:0];
    quo_nxt = {quo[n-2:0], ge};
  end

endmodule

// File: rtl/div_mod_seq.sv
// Multi-cycle unsigned divide/modulo unit: one shift-subtract iteration per clock,
// results and flags registered and held until the consumer accepts them.
module div_mod_seq
  import cpu_div_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_mod_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(n);

  div_state_t   state;
  logic [CW-1:0] cnt;
  logic [n-1:0] rem, quo, dvs;
  logic [n-1:0] rem_nxt, quo_nxt, res;
  logic         op_q;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [n-1:0] c_q;
  logic [3:0]   flags_q;

  div_step #(.n(n)) u_step (
    .rem     (rem),
    .quo     (quo),
    .b       (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign res = (op_q == OP_DIV) ? quo_nxt : rem_nxt;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.banderas  = flags_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      op_q        <= OP_MOD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            op_q       <= bus.op;
            dvs        <= bus.b;
            if (bus.b == '0) begin
              // Result is known now; out_valid follows one edge later in DONE.
              state   <= DONE;
              c_q     <= (bus.op == OP_DIV) ? '1 : bus.a;
              flags_q <= make_flags((bus.op == OP_MOD) && (bus.a == '0), 1'b1);
            end else begin
              state <= RUN;
              cnt   <= '0;
              rem   <= '0;
              quo   <= bus.a;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == CW'(n - 1)) begin
            cnt         <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
            c_q         <= res;
            flags_q     <= make_flags(res == '0, 1'b0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mod_seq.sv
// Scoreboard bench for div_mod_seq: accepted requests push an arithmetic-model result,
// a negedge monitor checks latency, hold-under-backpressure, handshake gaps and values.
module tb_div_mod_seq;
  import cpu_div_pkg::*;

  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;

  div_mod_seq_if #(.n(N)) bus ();

  div_mod_seq #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] c;
    logic [3:0]   f;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic opx, input logic [N-1:0] ax, input logic [N-1:0] bx);
    exp_t e;
    if (bx == 0) begin
      e.c   = opx ? {N{1'b1}} : ax;
      e.lat = 1;
    end else begin
      e.c   = opx ? ax / bx : ax % bx;
      e.lat = N;
    end
    e.f = {1'b0, e.c == 0, 1'b0, bx == 0};
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor
  logic         ov_seen = 1'b0;
  logic         post_rst = 1'b0;
  logic         post_hs = 1'b0;
  logic [N-1:0] held_c;
  logic [3:0]   held_f;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      ov_seen  = 1'b0;
      post_rst = 1'b1;
      post_hs  = 1'b0;
    end else begin
      if (post_rst) begin
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_c", bus.c, 0);
        chk("reset_banderas", bus.banderas, 0);
        chk("reset_busy", bus.busy, 0);
        post_rst = 1'b0;
      end
      if (post_hs) begin
        chk("gap_in_ready", bus.in_ready, 1);
        chk("gap_out_valid", bus.out_valid, 0);
        post_hs = 1'b0;
      end
      chk("busy_vs_in_ready", bus.busy, !bus.in_ready);
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.op, bus.a, bus.b);
        e.acc_cyc = cyc;
        sbq.push_back(e);
      end
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got c=%0h with no request pending", bus.c);
        end else begin
          if (!ov_seen) begin
            chk("latency", 64'(cyc - sbq[0].acc_cyc - 1), 64'(sbq[0].lat));
            ov_seen = 1'b1;
            held_c  = bus.c;
            held_f  = bus.banderas;
          end else begin
            chk("hold_c", bus.c, held_c);
            chk("hold_banderas", bus.banderas, held_f);
          end
          chk("in_ready_in_done", bus.in_ready, 0);
          if (bus.out_ready) begin
            chk("result_c", bus.c, sbq[0].c);
            chk("result_banderas", bus.banderas, sbq[0].f);
            void'(sbq.pop_front());
            ov_seen = 1'b0;
            post_hs = 1'b1;
          end
        end
      end
    end
  end

  // Consumer ready
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  task automatic send(input logic o, input logic [N-1:0] x, input logic [N-1:0] y);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a  = x;
    bus.b  = y;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 1'($urandom);
    bus.a  = $urandom;
    bus.b  = $urandom;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (sbq.size() == 0 && bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sbq.size());
    end
    #1;
  endtask

  function automatic logic [N-1:0] rand_b();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return N'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic         d_op[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [N-1:0] d_a[7]  = '{32'd17, 32'd100, 32'd0, 32'h0000_1234, 32'd5,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [N-1:0] d_b[7]  = '{32'd5, 32'd7, 32'd9, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF};

  initial begin
    bus.in_valid = 1'b0;
    bus.op = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed cases
    for (int i = 0; i < 7; i++) begin
      send(d_op[i], d_a[i], d_b[i]);
      drain();
    end

    // Backpressure held in DONE
    rdy_force = 1'b0;
    send(1'b0, 32'd50, 32'd7);
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rdy_force = 1'b1;
    drain();

    // Reset part-way through an operation
    send(1'b1, 32'h8765_4321, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b0, 32'd9, 32'd4);
    drain();

    // in_valid held high with operands changing every cycle
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1;
      bus.op = 1'($urandom);
      bus.a  = $urandom;
      bus.b  = rand_b();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Random individual requests under random backpressure
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom), $urandom, rand_b());
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
